mod_counter_prog: RTL

//  Parametrised, runtime-programmable modulo counter; next-generation time-base for the digital clock.

---
 rtl/clk_pkg.sv | 16 +
 rtl/mod_counter_prog_if.sv | 32 +++
 rtl/mod_counter_prog.sv | 114 +++++++++++
 3 files changed

// File: rtl/clk_pkg.sv
// Shared constants for the digital-clock time-base.
// Provides the direction encoding, the system clock rate and the
// standard moduli used by the ms -> s -> min -> h cascade.
package clk_pkg;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   localparam int unsigned CLK_HZ  = 50_000_000;

   localparam int unsigned MOD_1MS = 50000;
   localparam int unsigned MOD_1S  = 1000;
   localparam int unsigned MOD_60  = 60;
   localparam int unsigned MOD_24  = 24;

endpackage

// File: rtl/mod_counter_prog_if.sv
// Control/status bundle of the programmable modulo counter.
// master : the controller driving en/clr/dir/oneshot/mod_wr/mod_val/load/load_val
// slave  : the counter, returning cnt/tc/done/mod_err
interface mod_counter_prog_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             en;
   logic             clr;
   logic             dir;
   logic             oneshot;
   logic             mod_wr;
   logic [WIDTH-1:0] mod_val;
   logic             load;
   logic [WIDTH-1:0] load_val;

   logic [WIDTH-1:0] cnt;
   logic             tc;
   logic             done;
   logic             mod_err;

   modport master (
      output en, clr, dir, oneshot, mod_wr, mod_val, load, load_val,
      input  cnt, tc, done, mod_err
   );

   modport slave (
      input  en, clr, dir, oneshot, mod_wr, mod_val, load, load_val,
      output cnt, tc, done, mod_err
   );

endinterface

// File: rtl/mod_counter_prog.sv
// Runtime-programmable modulo counter for the digital-clock time-base.
// Counts enabled cycles modulo a programmable value, up or down, free-running
// or one-shot, with preload and a shadowed modulus applied only at a wrap/clr.
// Ports:
//   clk  - system clock, all state on posedge
//   rst  - synchronous active-high reset, overrides everything
//   bus  - slave side of mod_counter_prog_if (controls in, cnt/tc/done/mod_err out)
// tc is combinational from registered state so a cascaded stage can advance
// on the same edge as this stage wraps.
module mod_counter_prog
   import clk_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned DEFAULT_MOD = MOD_1MS
) (
   input  logic                clk,
   input  logic                rst,
   mod_counter_prog_if.slave   bus
);

   localparam logic [WIDTH-1:0] RST_MOD  = WIDTH'(DEFAULT_MOD);
   localparam logic [WIDTH-1:0] RST_TERM = WIDTH'(DEFAULT_MOD - 1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q,      cnt_d;
   logic [WIDTH-1:0] mod_act_q,  mod_act_d;
   logic [WIDTH-1:0] term_val_q, term_val_d;
   logic [WIDTH-1:0] mod_pend_q, mod_pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             done_q,     done_d;
   logic             mod_err_q,  mod_err_d;

   logic             term_c;
   logic [WIDTH-1:0] mod_eff_c;

   // Terminal state: top of range counting up, zero counting down.
   assign term_c    = (bus.dir == DIR_UP) ? (cnt_q == term_val_q) : (cnt_q == '0);
   // Modulus that a wrap or clr would adopt.
   assign mod_eff_c = pend_vld_q ? mod_pend_q : mod_act_q;

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         mod_act_q  <= RST_MOD;
         term_val_q <= RST_TERM;
         mod_pend_q <= RST_MOD;
         pend_vld_q <= 1'b0;
         done_q     <= 1'b0;
         mod_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         mod_act_q  <= mod_act_d;
         term_val_q <= term_val_d;
         mod_pend_q <= mod_pend_d;
         pend_vld_q <= pend_vld_d;
         done_q     <= done_d;
         mod_err_q  <= mod_err_d;
      end
   end

   // Next-state: clr > load > count, then shadow-modulus capture.
   always_comb begin
      cnt_d      = cnt_q;
      mod_act_d  = mod_act_q;
      mod_pend_d = mod_pend_q;
      pend_vld_d = pend_vld_q;
      done_d     = done_q;
      mod_err_d  = 1'b0;

      if (bus.clr) begin
         mod_act_d  = mod_eff_c;
         pend_vld_d = 1'b0;
         done_d     = 1'b0;
         cnt_d      = (bus.dir == DIR_DN) ? (mod_eff_c - ONE) : '0;
      end else if (bus.load) begin
         done_d = 1'b0;
         if (bus.load_val < mod_act_q) begin
            cnt_d = bus.load_val;
         end else begin
            cnt_d     = term_val_q;
            mod_err_d = 1'b1;
         end
      end else if (bus.en && !done_q) begin
         if (!term_c) begin
            cnt_d = (bus.dir == DIR_DN) ? (cnt_q - ONE) : (cnt_q + ONE);
         end else if (bus.oneshot) begin
            done_d = 1'b1;
         end else begin
            mod_act_d  = mod_eff_c;
            pend_vld_d = 1'b0;
            cnt_d      = (bus.dir == DIR_DN) ? (mod_eff_c - ONE) : '0;
         end
      end

      // Applied after the wrap/clr so a same-edge write becomes the next pending value.
      if (bus.mod_wr) begin
         if (bus.mod_val == '0) begin
            mod_err_d = 1'b1;
         end else begin
            mod_pend_d = bus.mod_val;
            pend_vld_d = 1'b1;
         end
      end

      term_val_d = mod_act_d - ONE;
   end

   assign bus.cnt     = cnt_q;
   assign bus.done    = done_q;
   assign bus.mod_err = mod_err_q;
   assign bus.tc      = bus.en & term_c & ~done_q & ~bus.clr & ~bus.load & ~rst;

endmodule
